// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer:
// state encoding, table entry layout and well-known field values.
package cam_cfg_pkg;

    localparam int ENTRY_W = 32;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_LOAD,
        ST_REQ,
        ST_WAIT,
        ST_DLY,
        ST_GAP,
        ST_DONE
    } cfg_state_e;

    // Entry layout: [31:24] device, [23:8] register address, [7:0] value
    typedef struct packed {
        logic [7:0]  dev;
        logic [15:0] regaddr;
        logic [7:0]  val;
    } cfg_entry_t;

    // Device field value that turns an entry into a delay marker
    localparam logic [7:0] DLY_MARK = 8'hFF;
    // Default sensor device address
    localparam logic [7:0] DEV_ADDR = 8'h78;

    function automatic cfg_entry_t mk_entry(input logic [7:0] dev,
                                            input logic [15:0] regaddr,
                                            input logic [7:0] val);
        cfg_entry_t e;
        e.dev     = dev;
        e.regaddr = regaddr;
        e.val     = val;
        return e;
    endfunction

    // A delay marker carries its unit count in the low 16 bits of the entry
    function automatic logic [15:0] dly_count(input cfg_entry_t e);
        return {e.regaddr[7:0], e.val};
    endfunction

endpackage

// File: rtl/cam_cfg_seq_if.sv
// Write-request channel between the configuration sequencer and the
// downstream I2C write engine.
interface cam_cfg_seq_if;
    import cam_cfg_pkg::*;

    logic [ENTRY_W-1:0] cfg_data;
    logic               i2c_req;
    logic               i2c_ack;

    modport master (output cfg_data, output i2c_req, input i2c_ack);
    modport slave  (input cfg_data, input i2c_req, output i2c_ack);
endinterface

// File: rtl/cam_cfg_rom.sv
// Sensor register list: indexed case table with a registered output
// (one cycle from addr to data). Entry 1 is a 2-unit delay marker.
module cam_cfg_rom
    import cam_cfg_pkg::*;
(
    input  logic               clk,
    input  logic [7:0]         addr,
    output logic [ENTRY_W-1:0] data
);

    logic [ENTRY_W-1:0] data_d;
    logic [ENTRY_W-1:0] data_q;

    // Table lookup for the presented index
    always_comb begin
        data_d = '0;
        case (addr)
            8'd0:    data_d = mk_entry(DEV_ADDR, 16'h3008, 8'h82);
            8'd1:    data_d = {DLY_MARK, 24'h00_0002};
            8'd2:    data_d = mk_entry(DEV_ADDR, 16'h3008, 8'h42);
            8'd3:    data_d = mk_entry(DEV_ADDR, 16'h3103, 8'h03);
            8'd4:    data_d = mk_entry(DEV_ADDR, 16'h3017, 8'hFF);
            8'd5:    data_d = mk_entry(DEV_ADDR, 16'h3018, 8'hFF);
            8'd6:    data_d = mk_entry(DEV_ADDR, 16'h3034, 8'h1A);
            8'd7:    data_d = mk_entry(DEV_ADDR, 16'h3035, 8'h11);
            default: data_d = '0;
        endcase
    end

    // Output register gives the table its one-cycle latency
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/cam_cfg_seq.sv
// Camera register-configuration sequencer. Waits out power-up, then walks
// the register table issuing one I2C write at a time, honouring delay
// markers and an inter-write gap, and raises cfg_done when finished.
// Optional ack watchdog: define CAM_CFG_TIMEOUT_EN.
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter int CFG_NUM  = 8,
    parameter int PWR_DLY  = 2000000,
    parameter int GAP_DLY  = 1000,
    parameter int DLY_UNIT = 100000
`ifdef CAM_CFG_TIMEOUT_EN
   ,parameter int TIMEOUT  = 200000
`endif
) (
    input  logic          clk_100,
    input  logic          rst_100,
    input  logic          cfg_start,
    cam_cfg_seq_if.master i2c,
    output logic [7:0]    cfg_idx,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_err
);

    cfg_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tgt_q, tgt_d;
    logic        ld_ph_q, ld_ph_d;
    cfg_entry_t  data_q, data_d;
    logic        req_q, req_d;
    logic [7:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef CAM_CFG_TIMEOUT_EN
    logic        err_q, err_d;
`endif

    logic [ENTRY_W-1:0] rom_word;
    cfg_entry_t         rom_entry;

    cam_cfg_rom u_rom (
        .clk  (clk_100),
        .addr (idx_q),
        .data (rom_word)
    );

    assign rom_entry = rom_word;

    // Delay length in cycles, clamped to the 32-bit counter range
    function automatic logic [31:0] sat_dly(input logic [15:0] units);
        logic [47:0] prod;
        prod = 48'(units) * 48'(DLY_UNIT);
        return (|prod[47:32]) ? 32'hFFFF_FFFF : prod[31:0];
    endfunction

    // Counter step that sticks at all-ones instead of wrapping
    function automatic logic [31:0] cnt_inc(input logic [31:0] c);
        return (&c) ? c : c + 32'd1;
    endfunction

    // Next-state and next-output decode for the sequencer FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        ld_ph_d = ld_ph_q;
        data_d  = data_q;
        req_d   = 1'b0;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef CAM_CFG_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_PWR: begin
                if (cnt_q >= 32'(PWR_DLY - 1)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    ld_ph_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            ST_LOAD: begin
                // First cycle lets the ROM register the current index
                if (!ld_ph_q) begin
                    ld_ph_d = 1'b1;
                end else begin
                    ld_ph_d = 1'b0;
                    data_d  = rom_entry;
                    cnt_d   = '0;
                    if (rom_entry.dev == DLY_MARK) begin
                        state_d = ST_DLY;
                        tgt_d   = sat_dly(dly_count(rom_entry));
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (i2c.i2c_ack) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
`ifdef CAM_CFG_TIMEOUT_EN
                end else if (cnt_q >= 32'(TIMEOUT - 1)) begin
                    // Engine never answered: flag it and move on
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
`endif
                end
            end
            ST_DLY: begin
                // A zero-length marker still spends one cycle here
                if (({1'b0, cnt_q} + 33'd1) >= {1'b0, tgt_q}) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            ST_GAP: begin
                if (cnt_q >= 32'(GAP_DLY - 1)) begin
                    cnt_d = '0;
                    if (idx_q >= 8'(CFG_NUM - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = idx_q + 8'd1;
                        ld_ph_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            ST_DONE: begin
                // Restart skips the power-up delay
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    ld_ph_d = 1'b0;
                    cnt_d   = '0;
`ifdef CAM_CFG_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_PWR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset takes priority over cfg_start
    always_ff @(posedge clk_100) begin
        if (rst_100) begin
            state_q <= ST_PWR;
            cnt_q   <= '0;
            tgt_q   <= '0;
            ld_ph_q <= 1'b0;
            data_q  <= '0;
            req_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef CAM_CFG_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ld_ph_q <= ld_ph_d;
            data_q  <= data_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CAM_CFG_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign i2c.cfg_data = data_q;
    assign i2c.i2c_req  = req_q;
    assign cfg_idx      = idx_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
`ifdef CAM_CFG_TIMEOUT_EN
    assign cfg_err      = err_q;
`else
    assign cfg_err      = 1'b0;
`endif

endmodule
